// File: rtl/ram_dma_rd_ctrl.sv
// DMA read controller: reads rd_len words, one byte per RAM access, from the
// external byte-wide RAM and pushes each assembled word into the downstream FIFO.
module ram_dma_rd_ctrl #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int RAM_DATA_WIDTH  = 8,
  parameter int BYTES_PER_BURST = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rd_start,
  input  logic [RAM_ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]       rd_len,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic [RAM_ADDR_WIDTH-1:0]  ram_rd_addr_r,
  output logic                       CE_bar_r,
  output logic                       RW_bar_r,
  output logic                       OE_bar_r,
  input  logic                       BUSY_bar_r,
  input  logic [RAM_DATA_WIDTH-1:0]  ram_rd_data,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data_in,
  output logic                       fifo_push,
  input  logic                       fifo_full
);
  localparam int BCW = (BYTES_PER_BURST > 1) ? $clog2(BYTES_PER_BURST) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_START  = 3'd1,
    RD_ADDR   = 3'd2,
    RD_OE     = 3'd3,
    RD_SAMPLE = 3'd4,
    PUSH      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                     state, state_n;
  logic [RAM_ADDR_WIDTH-1:0]  base_q, pc;
  logic [LEN_WIDTH-1:0]       len_q, word_cntr;
  logic [BCW-1:0]             byte_cntr;
  logic [FIFO_DATA_WIDTH-1:0] word_q, word_n;
  logic                       last_byte, last_word, push_ok;

  assign last_byte = (byte_cntr == BCW'(BYTES_PER_BURST - 1));
  assign last_word = (word_cntr == len_q - 1'b1);
  assign push_ok   = (state == PUSH) && !fifo_full;
  // Push follows fifo_full in the same cycle so a full FIFO is never written.
  assign fifo_push = push_ok;
  assign RW_bar_r  = 1'b1;

  always_comb begin
    state_n = state;
    word_n  = word_q;
    case (state)
      IDLE:      if (rd_start) state_n = (rd_len == '0) ? DONE : RD_START;
      RD_START:  state_n = RD_ADDR;
      RD_ADDR:   state_n = RD_OE;
      RD_OE:     if (BUSY_bar_r) state_n = RD_SAMPLE;
      RD_SAMPLE: begin
        word_n[32'(byte_cntr)*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] = ram_rd_data;
        state_n = last_byte ? PUSH : RD_START;
      end
      PUSH:      if (!fifo_full) state_n = last_word ? DONE : RD_START;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Strobes and address are registered from the next state so they switch
  // on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      pc            <= '0;
      byte_cntr     <= '0;
      word_cntr     <= '0;
      word_q        <= '0;
      rd_busy       <= 1'b0;
      rd_done       <= 1'b0;
      CE_bar_r      <= 1'b1;
      OE_bar_r      <= 1'b1;
      ram_rd_addr_r <= '0;
      fifo_data_in  <= '0;
    end else begin
      state  <= state_n;
      word_q <= word_n;
      if (state == IDLE && rd_start) begin
        base_q    <= base_addr;
        len_q     <= rd_len;
        pc        <= '0;
        byte_cntr <= '0;
        word_cntr <= '0;
        word_q    <= '0;
      end
      if (state == RD_SAMPLE) begin
        pc        <= pc + 1'b1;
        byte_cntr <= last_byte ? '0 : byte_cntr + 1'b1;
      end
      if (push_ok) word_cntr <= word_cntr + 1'b1;
      rd_busy       <= (state_n != IDLE);
      rd_done       <= (state_n == DONE);
      CE_bar_r      <= !(state_n inside {RD_START, RD_ADDR, RD_OE, RD_SAMPLE});
      OE_bar_r      <= !(state_n inside {RD_OE, RD_SAMPLE});
      ram_rd_addr_r <= (state_n inside {RD_ADDR, RD_OE, RD_SAMPLE}) ? base_q + pc : '0;
      fifo_data_in  <= (state_n == PUSH) ? word_n : '0;
    end
  end
endmodule

// File: doc/ram_dma_rd_ctrl.md
# ram_dma_rd_ctrl

DMA read controller for the byte-wide external RAM port: on a start command it reads `rd_len` 32-bit words from RAM starting at `base_addr` and pushes them into the downstream FIFO. It is the read-side counterpart of the DMA write controller. It uses the same CE/RW/OE/BUSY strobe protocol, the same one-byte-per-access sequencing, and the same byte order (byte 0 maps to bits [7:0]). A stored word written by the write path is therefore read back bit-identical.

## Interface
- `FIFO_DATA_WIDTH`, 32, FIFO word width; must equal `BYTES_PER_BURST*RAM_DATA_WIDTH`.
- `RAM_ADDR_WIDTH`, 16, RAM address width.
- `RAM_DATA_WIDTH`, 8, RAM data width (one byte per access).
- `BYTES_PER_BURST`, 4, bytes per FIFO word.
- `LEN_WIDTH`, 16, width of the word-count input.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `rd_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `base_addr`  in  RAM_ADDR_WIDTH  first RAM byte address; sampled with `rd_start`.
- `rd_len`  in  LEN_WIDTH  number of words to read; sampled with `rd_start`.
- `rd_busy`  out  1  high in every state except IDLE.
- `rd_done`  out  1  one-cycle pulse when the transfer completes.
- `ram_rd_addr_r`  out  RAM_ADDR_WIDTH  RAM address; 0 when not driving.
- `CE_bar_r`  out  1  chip enable, active low.
- `RW_bar_r`  out  1  read/write select; held at 1 (read) at all times.
- `OE_bar_r`  out  1  output enable, active low.
- `BUSY_bar_r`  in  1  RAM port contention flag, active low.
- `ram_rd_data`  in  RAM_DATA_WIDTH  RAM read data.
- `fifo_data_in`  out  FIFO_DATA_WIDTH  assembled word.
- `fifo_push`  out  1  push strobe.
- `fifo_full`  in  1  FIFO full flag.

## Operation
- Registers:
  - `base_q` and `len_q`, latched on accepted `rd_start`.
  - `pc` (RAM_ADDR_WIDTH bits), `byte_cntr` (0..BYTES_PER_BURST-1) and `word_cntr` (LEN_WIDTH bits), all cleared on accepted `rd_start`.
  - `word_q`, the assembly register.
- Address: `ram_rd_addr_r = base_q + pc`, computed modulo 2^RAM_ADDR_WIDTH, so it wraps from the top of RAM to 0. `pc` increments once per byte.
- FSM states and transitions:
  - IDLE: all strobes inactive. On `rd_start`: if `rd_len==0` go to DONE, else go to RD_START.
  - RD_START: `CE_bar_r=0`; go to RD_ADDR.
  - RD_ADDR: `CE_bar_r=0`; address driven; go to RD_OE.
  - RD_OE: `CE_bar_r=0`, `OE_bar_r=0`, address driven. If `BUSY_bar_r==0`, stay in RD_OE. Otherwise go to RD_SAMPLE.
  - RD_SAMPLE: `CE_bar_r=0`, `OE_bar_r=0`, address driven. At the edge leaving this state, `word_q[byte_cntr*8 +: 8] <= ram_rd_data`, and both `pc` and `byte_cntr` increment. If `byte_cntr` was BYTES_PER_BURST-1, `byte_cntr` wraps to 0 and the FSM goes to PUSH; otherwise it goes to RD_START.
  - PUSH: strobes inactive; `fifo_data_in = word_q`. If `fifo_full==0`: `fifo_push=1` and `word_cntr` increments. Then go to DONE if `word_cntr==len_q-1`, else to RD_START. If `fifo_full==1`: stay in PUSH with `fifo_push=0`.
  - DONE: `rd_done=1`; go to IDLE.
  - Illegal encodings go to IDLE.
- `rd_start` is ignored while `rd_busy` is high.
- `fifo_push` is asserted only in PUSH with `fifo_full==0`, so the FIFO is never overrun.

## Timing
- Reset values:
  - FSM in IDLE.
  - `CE_bar_r=1`, `OE_bar_r=1`, `RW_bar_r=1`.
  - `ram_rd_addr_r=0`, `fifo_data_in=0`, `fifo_push=0`, `rd_done=0`, `rd_busy=0`.
  - All counters and `word_q` cleared.
- Reset mid-transfer: the next cycle reproduces the reset values exactly. The partial word is discarded and no push occurs.
- Per byte: 4 cycles (RD_START, RD_ADDR, RD_OE, RD_SAMPLE), plus one cycle for each cycle `BUSY_bar_r` is low in RD_OE.
- Per word: 4·BYTES_PER_BURST + 1 cycles, i.e. 17 at default parameters, with no BUSY stalls and FIFO not full.
- Latency: `rd_start` accepted at cycle 0 → first `fifo_push` at cycle 17 → with `rd_len=N`, push k (k=1..N) at cycle 17k → `rd_done` at cycle 17N+1.
- `rd_len==0`: `rd_done` at cycle 1; no RAM strobes, no push.
- `ram_rd_data` is sampled only at the edge leaving RD_SAMPLE; OE has then been low for at least 2 cycles.

## Test plan
- **Single word.** RAM[0x0010..0x0013] = 11,22,33,44; `base_addr=0x0010`, `rd_len=1`, `rd_start` at cycle 0. Required: one push of `0x44332211` at cycle 17, `rd_done` at cycle 18, `RW_bar_r` constant 1.
- **Wrap-around.** `base_addr=0xFFFE`, `rd_len=1`. Required: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in that order; pushed word assembled from them.
- **Backpressure.** `rd_len=2`, `fifo_full` held high for cycles 17–21. Required: no push while full; first push at cycle 22; second push at cycle 39; `rd_done` at cycle 40; `fifo_data_in` stable throughout the stall.
- **BUSY stall.** `BUSY_bar_r` low for 3 cycles during the first RD_OE. Required: address and strobes held; first push at cycle 20; data correct.
- **Zero length and ignored start.**
  - `rd_len=0` → `rd_done` at cycle 1, no strobes.
  - `rd_start` re-pulsed mid-transfer → ignored; the word count is unchanged.
- **Mid-transfer reset.** `reset_n` low at cycle 9 of a 2-word read. Required: all reset values next cycle and no push. A new `rd_start` afterwards completes normally from `pc=0`.
